// File: rtl/pix_pkg.sv
// -----------------------------------------------------------------------------
// pix_pkg
// Shared definitions for the frame buffer pixel source.
//   PIX_W   : width of one pixel value
//   COORD_W : width of the x/y pixel coordinates
//   state_e : raster scan phases (idle, active line, line blank, frame blank)
//   lastIdx : last index of a dimension, sized to the coordinate width
// -----------------------------------------------------------------------------
package pix_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_e;

    // Coordinates are compared against the last index rather than the count,
    // so a 1024-wide or 1024-tall frame still fits the 10-bit counters.
    function automatic logic [COORD_W-1:0] lastIdx(input int n);
        return COORD_W'(n - 1);
    endfunction

endpackage

// File: rtl/pix_raster_ctr.sv
// -----------------------------------------------------------------------------
// pix_raster_ctr
// Raster scan state machine for the frame buffer reader. Walks the frame in
// raster order, issues one memory read per active pixel and inserts
// horizontal and vertical blanking between lines and frames.
//
// Ports
//   clk_i      : pixel clock, rising edge
//   reset_i    : synchronous active-high reset
//   enable_i   : level request for continuous frame playback
//   rd_en_o    : memory read strobe (registered)
//   rd_addr_o  : memory read address (registered, linear counter)
//   x_o, y_o   : coordinates of the pixel being read this cycle
//   first_o    : the read this cycle is pixel (0,0)
//   last_o     : the read this cycle is pixel (WIDTH-1,HEIGHT-1)
// -----------------------------------------------------------------------------
module pix_raster_ctr
    import pix_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 45,
    parameter int ADDR_W  = 19
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    output logic               rd_en_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               first_o,
    output logic               last_o
);

    // One blank counter serves both HBLANK and VBLANK, so it is sized for
    // the longer of the two.
    localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BLK_W   = (BLK_MAX < 2) ? 1 : $clog2(BLK_MAX);

    localparam logic [COORD_W-1:0] LAST_COL = lastIdx(WIDTH);
    localparam logic [COORD_W-1:0] LAST_ROW = lastIdx(HEIGHT);
    localparam logic [BLK_W-1:0]   HB_LAST  = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0]   VB_LAST  = BLK_W'(V_BLANK - 1);
    localparam logic               ONE_COL  = (WIDTH == 1);
    localparam logic               ONE_PIX  = (WIDTH == 1) && (HEIGHT == 1);

    state_e               state_q;
    logic [COORD_W-1:0]   col_q;
    logic [COORD_W-1:0]   row_q;
    logic [BLK_W-1:0]     blank_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 rd_en_q;
    logic                 first_q;
    logic                 last_q;

    logic [COORD_W-1:0]   col_d;
    logic [COORD_W-1:0]   row_d;
    logic [BLK_W-1:0]     blank_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 lastCol;
    logic                 lastRow;
    logic                 startFrame;

    // Incremented counter values and the end-of-line / end-of-frame flags
    // shared by the state machine below.
    always_comb begin
        col_d   = col_q + COORD_W'(1);
        row_d   = row_q + COORD_W'(1);
        blank_d = blank_q + BLK_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        lastCol = (col_q == LAST_COL);
        lastRow = (row_q == LAST_ROW);
        // A frame begins from IDLE, or straight out of the final VBLANK
        // cycle so back-to-back frames carry no extra gap.
        startFrame = enable_i &&
                     ((state_q == IDLE) ||
                      ((state_q == VBLANK) && (blank_q == VB_LAST)));
    end

    // Raster state machine. Every stage-0 output is a register updated here,
    // so the read strobe and address leave the block glitch-free. The
    // address counter only advances on a read and reloads to zero at the
    // start of every frame.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            blank_q <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (startFrame) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            row_q   <= '0;
            blank_q <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= ONE_PIX;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                end
                ACTIVE: begin
                    addr_q  <= addr_d;
                    first_q <= 1'b0;
                    if (lastCol) begin
                        state_q <= HBLANK;
                        rd_en_q <= 1'b0;
                        blank_q <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        col_q  <= col_d;
                        last_q <= (col_d == LAST_COL) && lastRow;
                    end
                end
                HBLANK: begin
                    if (blank_q == HB_LAST) begin
                        blank_q <= '0;
                        if (lastRow) begin
                            state_q <= VBLANK;
                        end else begin
                            state_q <= ACTIVE;
                            row_q   <= row_d;
                            col_q   <= '0;
                            rd_en_q <= 1'b1;
                            // A one-column frame reaches its last pixel at the
                            // first read of the last line.
                            last_q  <= ONE_COL && (row_d == LAST_ROW);
                        end
                    end else begin
                        blank_q <= blank_d;
                    end
                end
                VBLANK: begin
                    // Enable is low here, otherwise startFrame would have
                    // taken the final cycle.
                    if (blank_q == VB_LAST) begin
                        state_q <= IDLE;
                        blank_q <= '0;
                    end else begin
                        blank_q <= blank_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = addr_q;
    assign x_o       = col_q;
    assign y_o       = row_q;
    assign first_o   = first_q;
    assign last_o    = last_q;

endmodule

// File: rtl/frame_buf_reader.sv
// -----------------------------------------------------------------------------
// frame_buf_reader
// Pixel source that replays an 8-bit frame buffer in raster order with
// camera-like blanking. Wraps the raster counter with a two-stage pipeline
// that lines the coordinates and frame flags up with the read data returned
// by a synchronous-read memory (one cycle of latency).
//
// Ports
//   pclk        : pixel clock, rising edge
//   reset       : synchronous active-high reset, aborts any frame in flight
//   enable      : level request for continuous frame playback
//   rd_en       : memory read strobe
//   rd_addr     : memory read address
//   rd_data     : memory read data, valid the cycle after rd_en
//   value       : pixel value
//   x, y        : pixel column / row
//   is_val      : value/x/y valid this cycle
//   frame_start : pulse with pixel (0,0)
//   frame_done  : pulse with pixel (WIDTH-1,HEIGHT-1)
// -----------------------------------------------------------------------------
module frame_buf_reader
    import pix_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 45,
    parameter int ADDR_W  = 19
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               enable,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic [PIX_W-1:0]   value,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               is_val,
    output logic               frame_start,
    output logic               frame_done
);

    logic               rdEn0;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic               first0;
    logic               last0;

    logic               s1Val_q;
    logic [COORD_W-1:0] s1X_q;
    logic [COORD_W-1:0] s1Y_q;
    logic               s1First_q;
    logic               s1Last_q;

    logic [PIX_W-1:0]   value_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               isVal_q;
    logic               frameStart_q;
    logic               frameDone_q;

    pix_raster_ctr #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .ADDR_W  (ADDR_W)
    ) u_raster (
        .clk_i     (pclk),
        .reset_i   (reset),
        .enable_i  (enable),
        .rd_en_o   (rdEn0),
        .rd_addr_o (rd_addr),
        .x_o       (x0),
        .y_o       (y0),
        .first_o   (first0),
        .last_o    (last0)
    );

    // Stage 1: holds the pixel tag while the memory returns its data.
    // Clearing it on reset drops any read that was in flight.
    always_ff @(posedge pclk) begin
        if (reset) begin
            s1Val_q   <= 1'b0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
        end else begin
            s1Val_q   <= rdEn0;
            s1X_q     <= x0;
            s1Y_q     <= y0;
            s1First_q <= rdEn0 & first0;
            s1Last_q  <= rdEn0 & last0;
        end
    end

    // Stage 2: joins the tag with the read data. value/x/y only load on a
    // valid pixel so they hold the last pixel through blanking.
    always_ff @(posedge pclk) begin
        if (reset) begin
            value_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            isVal_q      <= 1'b0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end else begin
            isVal_q      <= s1Val_q;
            frameStart_q <= s1Val_q & s1First_q;
            frameDone_q  <= s1Val_q & s1Last_q;
            if (s1Val_q) begin
                value_q <= rd_data;
                x_q     <= s1X_q;
                y_q     <= s1Y_q;
            end
        end
    end

    assign rd_en       = rdEn0;
    assign value       = value_q;
    assign x           = x_q;
    assign y           = y_q;
    assign is_val      = isVal_q;
    assign frame_start = frameStart_q;
    assign frame_done  = frameDone_q;

endmodule
